// File: rtl/axis_cmd_arbiter_128.sv
// Two-port AXI4-Stream round-robin packet arbiter with a registered output stage.
// Define AXIS_ARB_STATS_EN to add the BEATS0/BEATS1 accepted-beat counters.
module axis_cmd_arbiter_128 #(
    parameter int C_DATA_WIDTH    = 128,
    parameter int C_LOCK_ON_TLAST = 1
) (
    input  logic                      AXIS_ACLK,
    input  logic                      AXIS_ARESET,
    input  logic [C_DATA_WIDTH-1:0]   S0_AXIS_TDATA,
    input  logic [C_DATA_WIDTH/8-1:0] S0_AXIS_TKEEP,
    input  logic                      S0_AXIS_TLAST,
    input  logic                      S0_AXIS_TVALID,
    output logic                      S0_AXIS_TREADY,
    input  logic [C_DATA_WIDTH-1:0]   S1_AXIS_TDATA,
    input  logic [C_DATA_WIDTH/8-1:0] S1_AXIS_TKEEP,
    input  logic                      S1_AXIS_TLAST,
    input  logic                      S1_AXIS_TVALID,
    output logic                      S1_AXIS_TREADY,
    output logic [C_DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                      M_AXIS_TLAST,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
`ifdef AXIS_ARB_STATS_EN
    output logic [31:0]               BEATS0,
    output logic [31:0]               BEATS1,
`endif
    output logic [1:0]                GRANT_ID
);

    localparam int KW   = C_DATA_WIDTH / 8;
    localparam bit LOCK = (C_LOCK_ON_TLAST != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t                  state;
    logic                    last_served;
    logic                    pkt_open;
    logic                    out_free;
    logic                    accept0;
    logic                    accept1;
    logic                    accept;
    logic                    release_evt;
    logic [C_DATA_WIDTH-1:0] sel_data;
    logic [KW-1:0]           sel_keep;
    logic                    sel_last;

    assign out_free       = M_AXIS_TREADY || !M_AXIS_TVALID;
    assign S0_AXIS_TREADY = (state == GRANT0) && out_free;
    assign S1_AXIS_TREADY = (state == GRANT1) && out_free;
    assign accept0        = S0_AXIS_TREADY && S0_AXIS_TVALID;
    assign accept1        = S1_AXIS_TREADY && S1_AXIS_TVALID;
    assign accept         = accept0 || accept1;
    assign sel_data       = accept1 ? S1_AXIS_TDATA : S0_AXIS_TDATA;
    assign sel_keep       = accept1 ? S1_AXIS_TKEEP : S0_AXIS_TKEEP;
    assign sel_last       = accept1 ? S1_AXIS_TLAST : S0_AXIS_TLAST;
    assign release_evt    = accept && (!LOCK || sel_last);
    assign GRANT_ID       = state;

    // A grant held between packets (pkt_open low) is dropped once its port goes quiet,
    // so a port that finished its packet cannot starve the other one.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state       <= IDLE;
            last_served <= 1'b1;
            pkt_open    <= 1'b0;
        end else begin
            if (accept)
                pkt_open <= !release_evt;
            case (state)
                IDLE: begin
                    if (S0_AXIS_TVALID && S1_AXIS_TVALID)
                        state <= last_served ? GRANT0 : GRANT1;
                    else if (S0_AXIS_TVALID)
                        state <= GRANT0;
                    else if (S1_AXIS_TVALID)
                        state <= GRANT1;
                end
                GRANT0: begin
                    if (release_evt) begin
                        last_served <= 1'b0;
                        state <= S1_AXIS_TVALID ? GRANT1 : (S0_AXIS_TVALID ? GRANT0 : IDLE);
                    end else if (!pkt_open && !S0_AXIS_TVALID) begin
                        state <= S1_AXIS_TVALID ? GRANT1 : IDLE;
                    end
                end
                GRANT1: begin
                    if (release_evt) begin
                        last_served <= 1'b1;
                        state <= S0_AXIS_TVALID ? GRANT0 : (S1_AXIS_TVALID ? GRANT1 : IDLE);
                    end else if (!pkt_open && !S1_AXIS_TVALID) begin
                        state <= S0_AXIS_TVALID ? GRANT0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TKEEP  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (accept) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= sel_data;
            M_AXIS_TKEEP  <= sel_keep;
            M_AXIS_TLAST  <= sel_last;
        end else if (M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
        end
    end

`ifdef AXIS_ARB_STATS_EN
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            BEATS0 <= '0;
            BEATS1 <= '0;
        end else begin
            if (accept0)
                BEATS0 <= BEATS0 + 32'd1;
            if (accept1)
                BEATS1 <= BEATS1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_cmd_arbiter_128.sv
// Directed bench for axis_cmd_arbiter_128: a locked-packet instance plus a per-beat
// (C_LOCK_ON_TLAST=0) instance; stats checks are built when AXIS_ARB_STATS_EN is defined.
module tb_axis_cmd_arbiter_128;

    localparam int DW = 128;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } src_beat_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        int            cyc;
    } out_beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
    logic          s0_tlast, s1_tlast, m_tlast;
    logic          s0_tvalid, s1_tvalid, m_tvalid;
    logic          s0_tready, s1_tready, m_tready;
    logic [1:0]    grant_id;

    logic          n_s0_tvalid, n_s1_tvalid, n_s0_tready, n_s1_tready;
    logic [DW-1:0] n_m_tdata;
    logic [KW-1:0] n_m_tkeep;
    logic          n_m_tlast, n_m_tvalid;
    logic [1:0]    n_grant_id;

`ifdef AXIS_ARB_STATS_EN
    logic [31:0]   beats0, beats1, n_beats0, n_beats1;
`endif

    axis_cmd_arbiter_128 #(.C_DATA_WIDTH(DW), .C_LOCK_ON_TLAST(1)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S0_AXIS_TDATA(s0_tdata), .S0_AXIS_TKEEP(s0_tkeep), .S0_AXIS_TLAST(s0_tlast),
        .S0_AXIS_TVALID(s0_tvalid), .S0_AXIS_TREADY(s0_tready),
        .S1_AXIS_TDATA(s1_tdata), .S1_AXIS_TKEEP(s1_tkeep), .S1_AXIS_TLAST(s1_tlast),
        .S1_AXIS_TVALID(s1_tvalid), .S1_AXIS_TREADY(s1_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TLAST(m_tlast),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
`ifdef AXIS_ARB_STATS_EN
        .BEATS0(beats0), .BEATS1(beats1),
`endif
        .GRANT_ID(grant_id)
    );

    axis_cmd_arbiter_128 #(.C_DATA_WIDTH(DW), .C_LOCK_ON_TLAST(0)) dut_nolock (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S0_AXIS_TDATA(128'hC000), .S0_AXIS_TKEEP(16'hFFFF), .S0_AXIS_TLAST(1'b0),
        .S0_AXIS_TVALID(n_s0_tvalid), .S0_AXIS_TREADY(n_s0_tready),
        .S1_AXIS_TDATA(128'hD000), .S1_AXIS_TKEEP(16'hFFFF), .S1_AXIS_TLAST(1'b0),
        .S1_AXIS_TVALID(n_s1_tvalid), .S1_AXIS_TREADY(n_s1_tready),
        .M_AXIS_TDATA(n_m_tdata), .M_AXIS_TKEEP(n_m_tkeep), .M_AXIS_TLAST(n_m_tlast),
        .M_AXIS_TVALID(n_m_tvalid), .M_AXIS_TREADY(1'b1),
`ifdef AXIS_ARB_STATS_EN
        .BEATS0(n_beats0), .BEATS1(n_beats1),
`endif
        .GRANT_ID(n_grant_id)
    );

    src_beat_t     q0[$];
    src_beat_t     q1[$];
    out_beat_t     outq[$];
    logic [1:0]    grant_log[$];
    logic [DW-1:0] n_out[$];
    logic          fire0 = 1'b0;
    logic          fire1 = 1'b0;
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;

    // Edge-time observation: handshakes, output beats and the grant at each accepted input beat.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        fire0 <= !rst && s0_tvalid && s0_tready;
        fire1 <= !rst && s1_tvalid && s1_tready;
        if (!rst && m_tvalid && m_tready)
            outq.push_back('{m_tdata, m_tkeep, m_tlast, cyc});
        if (!rst && ((s0_tvalid && s0_tready) || (s1_tvalid && s1_tready)))
            grant_log.push_back(grant_id);
        if (!rst && n_m_tvalid)
            n_out.push_back(n_m_tdata);
    end

    // Source models: a beat leaves its queue only after the DUT accepted it.
    always @(negedge clk) begin
        if (fire0 && q0.size() > 0) q0.delete(0);
        if (fire1 && q1.size() > 0) q1.delete(0);
        if (q0.size() > 0) begin
            s0_tvalid = 1'b1; s0_tdata = q0[0].d; s0_tkeep = q0[0].k; s0_tlast = q0[0].l;
        end else begin
            s0_tvalid = 1'b0;
        end
        if (q1.size() > 0) begin
            s1_tvalid = 1'b1; s1_tdata = q1[0].d; s1_tkeep = q1[0].k; s1_tlast = q1[0].l;
        end else begin
            s1_tvalid = 1'b0;
        end
    end

    task automatic push0(input int i, input logic l);
        q0.push_back('{128'hA000 + DW'(i), 16'h0FFF, l});
    endtask

    task automatic push1(input int i, input logic l);
        q1.push_back('{128'hB000 + DW'(i), 16'hFFF0, l});
    endtask

    task automatic wait_outs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (outq.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        m_tready = 1'b1;
        n_s0_tvalid = 1'b0;
        n_s1_tvalid = 1'b0;
        @(negedge clk);
        outq.delete();
        grant_log.delete();
        n_out.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid: got %b expected 0", m_tvalid); end
        total++; if (grant_id !== 2'b00) begin bad++; $display("[TB] FAIL reset_grant: got %b expected 00", grant_id); end
        total++; if (m_tdata !== '0) begin bad++; $display("[TB] FAIL reset_tdata: got %h expected 0", m_tdata); end
        total++; if (m_tkeep !== '0 || m_tlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_keep_last: got %h/%b expected 0/0", m_tkeep, m_tlast); end
    endtask

    task automatic test_tie();
        bit            ok;
        logic [DW-1:0] ed;
        logic [KW-1:0] ek;
        logic          el;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            push0(i, i == 2);
            push1(i, i == 2);
        end
        wait_outs(6, ok);
        total++;
        if (!ok) begin
            bad++; $display("[TB] FAIL tie_timeout: got %0d beats expected 6", outq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                ed = (i < 3) ? 128'hA000 + DW'(i) : 128'hB000 + DW'(i - 3);
                ek = (i < 3) ? 16'h0FFF : 16'hFFF0;
                el = (i == 2) || (i == 5);
                total++; if (outq[i].d !== ed) begin bad++; $display("[TB] FAIL tie_data[%0d]: got %h expected %h", i, outq[i].d, ed); end
                total++; if (outq[i].k !== ek || outq[i].l !== el) begin bad++; $display("[TB] FAIL tie_keep_last[%0d]: got %h/%b expected %h/%b", i, outq[i].k, outq[i].l, ek, el); end
                total++; if (outq[i].cyc !== outq[0].cyc + i) begin bad++; $display("[TB] FAIL tie_gap[%0d]: got cycle %0d expected %0d", i, outq[i].cyc, outq[0].cyc + i); end
            end
        end
    endtask

    task automatic test_lock();
        bit            ok;
        logic [DW-1:0] ed;
        logic [1:0]    eg;
        apply_reset();
        for (int i = 0; i < 4; i++) push0(i, i == 3);
        wait_outs(1, ok);
        for (int i = 0; i < 3; i++) push1(i, i == 2);
        total++; if (grant_id !== 2'b01) begin bad++; $display("[TB] FAIL lock_grant_mid: got %b expected 01", grant_id); end
        wait_outs(7, ok);
        total++;
        if (!ok || grant_log.size() < 7) begin
            bad++; $display("[TB] FAIL lock_timeout: got %0d beats expected 7", outq.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                ed = (i < 4) ? 128'hA000 + DW'(i) : 128'hB000 + DW'(i - 4);
                eg = (i < 4) ? 2'b01 : 2'b10;
                total++; if (outq[i].d !== ed) begin bad++; $display("[TB] FAIL lock_data[%0d]: got %h expected %h", i, outq[i].d, ed); end
                total++; if (grant_log[i] !== eg) begin bad++; $display("[TB] FAIL lock_grant[%0d]: got %b expected %b", i, grant_log[i], eg); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit            ok;
        logic [DW-1:0] ed;
        apply_reset();
        for (int i = 0; i < 6; i++) push0(i, i == 5);
        wait_outs(2, ok);
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (m_tvalid !== 1'b1 || m_tdata !== 128'hA002) begin bad++; $display("[TB] FAIL bp_hold[%0d]: got %b/%h expected 1/%h", c, m_tvalid, m_tdata, 128'hA002); end
            total++; if (s0_tready !== 1'b0) begin bad++; $display("[TB] FAIL bp_tready[%0d]: got %b expected 0", c, s0_tready); end
        end
        m_tready = 1'b1;
        wait_outs(6, ok);
        repeat (4) @(negedge clk);
        total++;
        if (outq.size() != 6) begin
            bad++; $display("[TB] FAIL bp_count: got %0d beats expected 6", outq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                ed = 128'hA000 + DW'(i);
                total++; if (outq[i].d !== ed) begin bad++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", i, outq[i].d, ed); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        push0(0, 1'b1);
        for (int i = 0; i < 4; i++) push1(i, i == 3);
        wait_outs(2, ok);
        #1 rst = 1'b1;
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_tvalid: got %b expected 0", m_tvalid); end
        total++; if (grant_id !== 2'b00) begin bad++; $display("[TB] FAIL rmid_grant: got %b expected 00", grant_id); end
        total++; if (s1_tready !== 1'b0 || m_tdata !== '0) begin bad++; $display("[TB] FAIL rmid_clear: got %b/%h expected 0/0", s1_tready, m_tdata); end
        q0.delete();
        q1.delete();
        @(negedge clk);
        outq.delete();
        grant_log.delete();
        rst = 1'b0;
        push0(256, 1'b1);
        push1(256, 1'b1);
        wait_outs(2, ok);
        total++;
        if (!ok || grant_log.size() < 2) begin
            bad++; $display("[TB] FAIL rmid_timeout: got %0d beats expected 2", outq.size());
        end else begin
            total++; if (grant_log[0] !== 2'b01) begin bad++; $display("[TB] FAIL rmid_first_grant: got %b expected 01", grant_log[0]); end
            total++; if (outq[0].d !== 128'hA100 || outq[1].d !== 128'hB100) begin bad++; $display("[TB] FAIL rmid_order: got %h,%h expected %h,%h", outq[0].d, outq[1].d, 128'hA100, 128'hB100); end
        end
    endtask

    task automatic test_no_lock();
        logic [DW-1:0] ed;
        apply_reset();
        n_s0_tvalid = 1'b1;
        n_s1_tvalid = 1'b1;
        for (int i = 0; i < 100 && n_out.size() < 6; i++) @(negedge clk);
        n_s0_tvalid = 1'b0;
        n_s1_tvalid = 1'b0;
        total++;
        if (n_out.size() < 6) begin
            bad++; $display("[TB] FAIL nolock_timeout: got %0d beats expected 6", n_out.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                ed = (i % 2 == 0) ? 128'hC000 : 128'hD000;
                total++; if (n_out[i] !== ed) begin bad++; $display("[TB] FAIL nolock_alt[%0d]: got %h expected %h", i, n_out[i], ed); end
            end
        end
    endtask

`ifdef AXIS_ARB_STATS_EN
    task automatic test_stats();
        bit ok;
        apply_reset();
        for (int i = 0; i < 10; i++) push0(i, i == 4 || i == 9);
        for (int i = 0; i < 7; i++) push1(i, i == 6);
        wait_outs(17, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL stats_timeout: got %0d beats expected 17", outq.size()); end
        total++; if (beats0 !== 32'd10) begin bad++; $display("[TB] FAIL stats_beats0: got %0d expected 10", beats0); end
        total++; if (beats1 !== 32'd7) begin bad++; $display("[TB] FAIL stats_beats1: got %0d expected 7", beats1); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        m_tready = 1'b1;
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0;
        n_s0_tvalid = 1'b0;
        n_s1_tvalid = 1'b0;
        test_reset();
        test_tie();
        test_lock();
        test_backpressure();
        test_reset_mid();
        test_no_lock();
`ifdef AXIS_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_cmd_arbiter_128.md
AXIS_CMD_ARBITER_128 -- requirements
Module: axis_cmd_arbiter_128

Interface
REQ-001 SHALL provide parameter C_DATA_WIDTH, default 128, TDATA width in bits.
REQ-002 SHALL provide parameter C_LOCK_ON_TLAST, default 1; 1 holds the grant until the TLAST beat, 0 re-arbitrates after every accepted beat.
REQ-003 SHALL provide port AXIS_ACLK, input, 1, the single clock for all logic.
REQ-004 SHALL provide port AXIS_ARESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide ports S0_AXIS_TDATA/TKEEP/TLAST/TVALID, input, C_DATA_WIDTH/C_DATA_WIDTH/8/1/1, requester 0 stream.
REQ-006 SHALL provide port S0_AXIS_TREADY, output, 1, requester 0 ready.
REQ-007 SHALL provide ports S1_AXIS_TDATA/TKEEP/TLAST/TVALID, input, same widths, requester 1 stream.
REQ-008 SHALL provide port S1_AXIS_TREADY, output, 1, requester 1 ready.
REQ-009 SHALL provide ports M_AXIS_TDATA/TKEEP/TLAST/TVALID, output (registered), same widths, merged stream.
REQ-010 SHALL provide port M_AXIS_TREADY, input, 1, downstream ready.
REQ-011 SHALL provide port GRANT_ID, output, 2, 00 idle, 01 port 0 granted, 10 port 1 granted.

Function
REQ-012 SHALL implement an FSM with states IDLE, GRANT0 and GRANT1, with GRANT_ID encoding the state.
REQ-013 SHALL leave IDLE when either TVALID is high: one valid port is granted; both valid grants the port not served last (round-robin pointer).
REQ-014 SHALL drive Sn_AXIS_TREADY = (state==GRANTn) && (M_AXIS_TREADY || !M_AXIS_TVALID); the ungranted port's TREADY SHALL be 0.
REQ-015 SHALL load the output register with the granted port's TDATA/TKEEP/TLAST on each accepted beat and set M_AXIS_TVALID=1, giving 1-cycle latency.
REQ-016 SHALL clear M_AXIS_TVALID on an M handshake when no new beat is accepted in that cycle, and SHALL hold the output register stable while M_AXIS_TVALID && !M_AXIS_TREADY.
REQ-017 SHALL define a release event as: an accepted beat with TLAST=1 (C_LOCK_ON_TLAST=1), or any accepted beat (C_LOCK_ON_TLAST=0).
REQ-018 On release SHALL update the pointer to the served port and choose the next state in the same cycle: the other port if its TVALID is high, else the same port if valid, else IDLE (no bubble).
REQ-019 SHALL NOT change the grant while a packet is open, regardless of the other port's TVALID.
REQ-020 SHALL sustain 1 beat/cycle under continuous M_AXIS_TREADY=1, including across grant switches.
REQ-021 A granted port dropping TVALID mid-packet SHALL keep the grant (wait state) with no output beat inserted.

Reset
REQ-022 Asserting AXIS_ARESET SHALL immediately force: state IDLE, M_AXIS_TVALID=0, TDATA/TKEEP/TLAST=0, GRANT_ID=00, pointer set so port 0 wins the first tie.
REQ-023 Reset mid-packet SHALL discard the partial packet and the registered beat; after release, arbitration SHALL restart from REQ-013.

Configuration
REQ-024 With macro AXIS_ARB_STATS_EN defined, SHALL add outputs BEATS0 and BEATS1 (32 bits each, wrapping) counting accepted input beats per port, cleared by reset.
REQ-025 Without AXIS_ARB_STATS_EN, the BEATS0/BEATS1 ports and their counters SHALL be absent.

Verification
REQ-026 Tie: S0 and S1 both valid after reset, 3-beat packets, M ready=1 -> S0 packet (3 beats) then S1 packet (3 beats), no gap, TLAST on beats 3 and 6.
REQ-027 Lock: S0 sends 4-beat packet; S1 asserts valid at beat 2 -> S1 beats appear only after S0 TLAST; GRANT_ID 01 then 10.
REQ-028 Backpressure: M_AXIS_TREADY=0 for 5 cycles mid-packet -> output data held constant, S TREADY=0, no beat lost or duplicated.
REQ-029 C_LOCK_ON_TLAST=0, both ports valid continuously -> output alternates S0,S1,S0,S1 beat by beat.
REQ-030 Async reset asserted during S1 beat 2 of 4 -> M_AXIS_TVALID=0 and GRANT_ID=00 before the next clock edge; next tie granted to S0.
REQ-031 With AXIS_ARB_STATS_EN defined: 10 beats on S0, 7 on S1 -> BEATS0=10, BEATS1=7.
